// File: rtl/tick_monitor_pkg.sv
// Shared types and period-window arithmetic for the tick stream monitor.
package tick_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE
  } state_t;

  typedef longint unsigned u64_t;

  function automatic u64_t exp_cycles(input int unsigned interval_ms,
                                      input int unsigned cycles_per_ms);
    return u64_t'(interval_ms) * u64_t'(cycles_per_ms) + u64_t'(1);
  endfunction

  function automatic u64_t min_cycles(input u64_t exp_c, input int unsigned tol);
    return exp_c - u64_t'(tol);
  endfunction

  function automatic u64_t max_cycles(input u64_t exp_c, input int unsigned tol);
    return exp_c + u64_t'(tol);
  endfunction

  // The window must sit strictly above zero and fit the 32-bit counter.
  function automatic bit cfg_ok(input int unsigned interval_ms,
                                input int unsigned cycles_per_ms,
                                input int unsigned tol);
    u64_t e;
    e = exp_cycles(interval_ms, cycles_per_ms);
    return (u64_t'(tol) < e) && (max_cycles(e, tol) < 64'h1_0000_0000);
  endfunction

endpackage

// File: rtl/tick_monitor_if.sv
// Control input, tick stream and status outputs of the tick monitor.
interface tick_monitor_if;
  logic        enable;
  logic        tick_in;
  logic        tick_ok;
  logic        early;
  logic        missing;
  logic        locked;
  logic [31:0] period;
  logic [15:0] good_count;

  modport master (
    output enable, tick_in,
    input  tick_ok, early, missing, locked, period, good_count
  );

  modport slave (
    input  enable, tick_in,
    output tick_ok, early, missing, locked, period, good_count
  );
endinterface

// File: rtl/tick_monitor_pulse_edge_detect.sv
// Registered previous sample of a level plus its rising-edge strobe.
module pulse_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
endmodule

// File: rtl/tick_monitor.sv
// Measures the interval between tick rising edges, classifies it against
// an expected period window and tracks lock over consecutive good intervals.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int unsigned INTERVAL_MS   = 1000,
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int unsigned TOL_CYCLES    = 16,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input logic           clk,
  input logic           reset,
  tick_monitor_if.slave mon
);

  localparam u64_t        EXP64 = exp_cycles(INTERVAL_MS, CYCLES_PER_MS);
  localparam logic [31:0] MIN_C = 32'(min_cycles(EXP64, TOL_CYCLES));
  localparam logic [31:0] MAX_C = 32'(max_cycles(EXP64, TOL_CYCLES));
  localparam int unsigned SW    = $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0] LOCK_C = SW'(LOCK_COUNT);

  if (!cfg_ok(INTERVAL_MS, CYCLES_PER_MS, TOL_CYCLES)) begin : g_bad_window
    $error("tick_monitor: TOL_CYCLES >= EXP or MAX does not fit 32 bits");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("tick_monitor: LOCK_COUNT must be at least 1");
  end

  state_t        state, state_n;
  logic [31:0]   cnt, cnt_n;
  logic [31:0]   period, period_n;
  logic [15:0]   good, good_n;
  logic [SW-1:0] streak, streak_n;
  logic          locked, locked_n;
  logic          ok, ok_n;
  logic          early, early_n;
  logic          miss, miss_n;
  logic          tick_edge;
  logic [31:0]   interval;

  pulse_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (mon.tick_in),
    .rise  (tick_edge)
  );

  assign interval = cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      period <= '0;
      good   <= '0;
      streak <= '0;
      locked <= 1'b0;
      ok     <= 1'b0;
      early  <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      period <= period_n;
      good   <= good_n;
      streak <= streak_n;
      locked <= locked_n;
      ok     <= ok_n;
      early  <= early_n;
      miss   <= miss_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period;
    good_n   = good;
    streak_n = streak;
    locked_n = locked;
    ok_n     = 1'b0;
    early_n  = 1'b0;
    miss_n   = 1'b0;

    if (!mon.enable) begin
      state_n  = IDLE;
      streak_n = '0;
      locked_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n  = WAIT_FIRST;
          streak_n = '0;
          locked_n = 1'b0;
        end
        WAIT_FIRST: begin
          if (tick_edge) begin
            cnt_n   = '0;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          cnt_n = interval;
          // A tick landing exactly on MAX is classified, not reported missing.
          if (tick_edge) begin
            cnt_n    = '0;
            period_n = interval;
            if (interval < MIN_C) begin
              early_n  = 1'b1;
              streak_n = '0;
              locked_n = 1'b0;
            end else begin
              ok_n     = 1'b1;
              good_n   = (good == 16'hFFFF) ? good : good + 16'd1;
              streak_n = (streak == LOCK_C) ? streak : streak + 1'b1;
              if (streak_n == LOCK_C) locked_n = 1'b1;
            end
          end else if (interval == MAX_C) begin
            miss_n   = 1'b1;
            streak_n = '0;
            locked_n = 1'b0;
            state_n  = WAIT_FIRST;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign mon.tick_ok    = ok;
  assign mon.early      = early;
  assign mon.missing    = miss;
  assign mon.locked     = locked;
  assign mon.period     = period;
  assign mon.good_count = good;

endmodule

// File: tb/tb_tick_monitor.sv
// Randomised and directed checks of tick_monitor against an interval-based reference.
module tb_tick_monitor;

  localparam int EXP_C  = 11;
  localparam int MIN_C  = 9;
  localparam int MAX_C  = 13;
  localparam int LOCK_N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tick_monitor_if mon ();

  tick_monitor #(
    .INTERVAL_MS   (1),
    .CYCLES_PER_MS (10),
    .TOL_CYCLES    (2),
    .LOCK_COUNT    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int since    = 1000;
  logic en_v   = 1'b0;
  logic rst_v  = 1'b0;

  // Reference: intervals are differences of absolute sample indices.
  bit m_armed, m_have_ref, m_prev;
  int m_ref, m_streak;
  bit m_ok, m_early, m_miss, m_locked;
  int m_period, m_good;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_eval(input bit rst, input bit en, input bit tin);
    bit edge_s;
    int iv;
    edge_s  = tin && !m_prev;
    m_ok    = 0;
    m_early = 0;
    m_miss  = 0;
    if (rst) begin
      m_armed = 0; m_have_ref = 0; m_streak = 0;
      m_locked = 0; m_period = 0; m_good = 0;
    end else if (!en) begin
      m_armed = 0; m_have_ref = 0; m_streak = 0; m_locked = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_streak = 0; m_locked = 0;
    end else if (!m_have_ref) begin
      if (edge_s) begin
        m_have_ref = 1;
        m_ref = cyc;
      end
    end else begin
      iv = cyc - m_ref;
      if (edge_s) begin
        m_period = iv;
        m_ref = cyc;
        if (iv < MIN_C) begin
          m_early = 1; m_streak = 0; m_locked = 0;
        end else begin
          m_ok = 1;
          if (m_good < 65535) m_good++;
          if (m_streak < LOCK_N) m_streak++;
          if (m_streak == LOCK_N) m_locked = 1;
        end
      end else if (iv == MAX_C) begin
        m_miss = 1; m_have_ref = 0; m_streak = 0; m_locked = 0;
      end
    end
    m_prev = rst ? 1'b0 : tin;
  endtask

  task automatic step(input logic tin);
    mon.tick_in = tin;
    mon.enable  = en_v;
    reset       = rst_v;
    model_eval(rst_v, en_v, tin);
    since++;
    @(posedge clk);
    @(negedge clk);
    check_eq("tick_ok",    32'(mon.tick_ok),    32'(m_ok));
    check_eq("early",      32'(mon.early),      32'(m_early));
    check_eq("missing",    32'(mon.missing),    32'(m_miss));
    check_eq("locked",     32'(mon.locked),     32'(m_locked));
    check_eq("period",     mon.period,          32'(m_period));
    check_eq("good_count", 32'(mon.good_count), 32'(m_good));
    cyc++;
  endtask

  // Next rising sample lands iv samples after the previous one; held high for width.
  task automatic next_tick(input int iv, input int width);
    while (since + 1 < iv) step(1'b0);
    step(1'b1);
    since = 0;
    for (int i = 1; i < width; i++) step(1'b1);
  endtask

  int g0, miss_seen, iv, w, r;

  initial begin
    mon.enable  = 1'b0;
    mon.tick_in = 1'b0;

    rst_v = 1'b1;
    step(1'b0);
    step(1'b0);
    rst_v = 1'b0;
    check_eq("rst_period", mon.period, 32'd0);
    check_eq("rst_good", 32'(mon.good_count), 32'd0);

    // Steady stream at the nominal period.
    en_v = 1'b1;
    repeat (3) step(1'b0);
    next_tick(0, 1);
    check_eq("first_no_pulse", 32'(mon.tick_ok), 32'd0);
    for (int i = 0; i < 4; i++) next_tick(EXP_C, 1);
    check_eq("s1_good", 32'(mon.good_count), 32'd4);
    check_eq("s1_period", mon.period, 32'd11);
    check_eq("s1_locked", 32'(mon.locked), 32'd1);

    // Early tick after lock.
    next_tick(8, 1);
    check_eq("early_pulse", 32'(mon.early), 32'd1);
    check_eq("early_unlock", 32'(mon.locked), 32'd0);
    check_eq("early_period", mon.period, 32'd8);
    next_tick(EXP_C, 1);
    check_eq("post_early_ok", 32'(mon.tick_ok), 32'd1);
    check_eq("post_early_unlocked", 32'(mon.locked), 32'd0);
    next_tick(EXP_C, 1);
    next_tick(EXP_C, 1);
    check_eq("relock", 32'(mon.locked), 32'd1);

    // Stream stops: missing after MAX, then silence.
    repeat (12) step(1'b0);
    check_eq("no_miss_yet", 32'(mon.missing), 32'd0);
    step(1'b0);
    check_eq("miss_pulse", 32'(mon.missing), 32'd1);
    check_eq("miss_unlock", 32'(mon.locked), 32'd0);
    miss_seen = 0;
    repeat (50) begin
      step(1'b0);
      if (mon.missing) miss_seen++;
    end
    check_eq("gap_no_missing", 32'(miss_seen), 32'd0);

    // Window boundaries.
    next_tick(0, 1);
    check_eq("rearm_no_pulse", 32'(mon.tick_ok | mon.early), 32'd0);
    next_tick(MIN_C, 1);
    check_eq("min_ok", 32'(mon.tick_ok), 32'd1);
    next_tick(MAX_C, 1);
    check_eq("max_ok", 32'(mon.tick_ok), 32'd1);
    check_eq("max_no_miss", 32'(mon.missing), 32'd0);
    check_eq("max_period", mon.period, 32'd13);
    next_tick(MIN_C - 1, 1);
    check_eq("below_min_early", 32'(mon.early), 32'd1);

    // Wide ticks after an enable cycle: one classification per rising edge.
    en_v = 1'b0;
    step(1'b0);
    step(1'b0);
    check_eq("disable_unlock", 32'(mon.locked), 32'd0);
    en_v = 1'b1;
    step(1'b0);
    step(1'b0);
    g0 = m_good;
    next_tick(0, 4);
    for (int i = 0; i < 4; i++) next_tick(EXP_C, 4);
    check_eq("wide_good", 32'(mon.good_count), 32'(g0 + 4));
    check_eq("wide_locked", 32'(mon.locked), 32'd1);
    check_eq("wide_period", mon.period, 32'd11);

    // Reset mid-interval while locked.
    repeat (5) step(1'b0);
    rst_v = 1'b1;
    step(1'b0);
    rst_v = 1'b0;
    check_eq("mid_rst_locked", 32'(mon.locked), 32'd0);
    check_eq("mid_rst_period", mon.period, 32'd0);
    check_eq("mid_rst_good", 32'(mon.good_count), 32'd0);
    step(1'b0);
    step(1'b0);
    next_tick(0, 1);
    check_eq("post_rst_no_pulse", 32'(mon.tick_ok | mon.early | mon.missing), 32'd0);
    next_tick(EXP_C, 1);
    check_eq("post_rst_ok", 32'(mon.tick_ok), 32'd1);
    check_eq("post_rst_good", 32'(mon.good_count), 32'd1);

    // Random intervals, widths, enable drops and resets.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(99, 0));
      if (r < 3) begin
        rst_v = 1'b1;
        step(1'b0);
        rst_v = 1'b0;
      end else if (r < 7) begin
        en_v = 1'b0;
        repeat (int'($urandom_range(3, 1))) step(1'b0);
        en_v = 1'b1;
      end
      r = int'($urandom_range(9, 0));
      if (r < 6)      iv = int'($urandom_range(14, 8));
      else if (r < 8) iv = int'($urandom_range(7, 3));
      else            iv = int'($urandom_range(30, 14));
      w = int'($urandom_range(2, 1));
      next_tick(iv, w);
    end
    repeat (20) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Receive-side checker for a periodic single-cycle tick stream, such as the timeout pulse of an interval timer. It measures the clk-cycle interval between successive tick rising edges and classifies each interval as good, early or missing against an expected period with tolerance. It reports lock once enough consecutive good intervals have been seen. It sits downstream of any interval timer as a liveness and frequency monitor.

## Interface
- INTERVAL_MS, 1000: nominal tick interval in ms.
- CYCLES_PER_MS, 50000: clk cycles per ms.
- TOL_CYCLES, 16: allowed deviation, in cycles, either side of the expected period.
- LOCK_COUNT, 4: consecutive good intervals required to assert locked (≥1).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- enable  in  1  monitor enable; low forces IDLE.
- tick_in  in  1  tick stream; only rising edges count.
- tick_ok  out  1  one-cycle pulse: interval within window.
- early  out  1  one-cycle pulse: tick arrived before MIN.
- missing  out  1  one-cycle pulse: no tick by MAX.
- locked  out  1  level: LOCK_COUNT consecutive good intervals seen.
- period  out  32  last measured interval, in cycles.
- good_count  out  16  total good intervals, saturating.

## Operation
- Constants:
  - EXP = INTERVAL_MS*CYCLES_PER_MS + 1.
  - MIN = EXP − TOL_CYCLES.
  - MAX = EXP + TOL_CYCLES.
  - Elaboration error if TOL_CYCLES ≥ EXP or MAX ≥ 2^32.
- Edge detection: edge = tick_in & ~tick_q.
  - tick_q is registered every cycle in every state, including IDLE.
  - A tick held high across enable rising therefore produces no edge.
- States: IDLE, WAIT_FIRST, MEASURE.
- IDLE: edges ignored; locked = 0; streak = 0.
  - enable = 1 → WAIT_FIRST.
- WAIT_FIRST: no timeout applies.
  - On edge: cnt ← 0, go to MEASURE, no classification.
- MEASURE: each cycle, cnt ← cnt + 1; the current interval is cnt + 1.
- MEASURE, edge present, priority over missing:
  - period ← cnt + 1, cnt ← 0, stay in MEASURE.
  - If cnt + 1 < MIN: pulse early, streak ← 0, locked ← 0.
  - Otherwise: pulse tick_ok, good_count++ (saturate at 0xFFFF), streak++ (saturate at LOCK_COUNT).
  - locked ← 1 when streak reaches LOCK_COUNT.
- MEASURE, no edge, cnt + 1 == MAX:
  - Pulse missing; streak ← 0; locked ← 0.
  - Go to WAIT_FIRST; period unchanged.
- enable low in any state → IDLE next cycle.
  - In that cycle no pulses are issued and locked is cleared.
  - cnt, period and good_count hold their values.
- reset, in any state and mid-interval, has priority over all other events.
  - Next state is IDLE; cnt = 0, streak = 0, tick_q = 0.
  - All outputs go to 0, including period and good_count.

## Timing
- Every output is registered.
- tick_ok, early, missing and the period update appear on the cycle after the tick_in rising sample.
  - Each is high for exactly one cycle.
- locked rises in the same cycle as the LOCK_COUNT-th tick_ok pulse.
  - It falls in the same cycle as an early or missing pulse, or one cycle after enable falls.
- Interval definition: ticks sampled high at cycles t0 and t1 give period = t1 − t0.
  - Back-to-back edges are impossible; the minimum measurable period is 2.
- Missing fires on the cycle after the sample where cnt + 1 == MAX with no edge.
  - It never fires in WAIT_FIRST or IDLE.
- Back-to-back early ticks each pulse early; there is no dead time.

## Structure
- Package tick_monitor_pkg holds:
  - the state enum (IDLE, WAIT_FIRST, MEASURE);
  - the constant functions for EXP, MIN and MAX with their range checks.
- One sub-module, pulse_edge_detect: registered previous value plus rising-edge output.
- Everything else is flat in tick_monitor.

## Test plan
Common parameters: INTERVAL_MS=1, CYCLES_PER_MS=10, TOL_CYCLES=2, LOCK_COUNT=3, giving EXP=11, MIN=9, MAX=13.
- Ticks every 11 cycles, 5 ticks after enable → 4 tick_ok pulses; period=11; locked rises with the 3rd tick_ok; good_count=4.
- After lock, one tick at interval 8 → early pulse, locked=0, period=8; next interval 11 → tick_ok, not locked.
- After lock, stop ticking → missing pulse exactly 13 cycles after the last tick sample, locked=0, state WAIT_FIRST; a 50-cycle gap before the next tick raises no further missing.
- Boundary intervals → 9 and 13 give tick_ok; 8 gives early; with interval 13 the tick takes priority and there is no missing.
- tick_in held high for 4 cycles every 11 cycles → one classification per rising edge; identical to the first scenario.
- reset pulse mid-interval while locked → next cycle all outputs are 0 and state is IDLE; with enable still high, WAIT_FIRST follows and the first subsequent tick produces no pulse.
